// File: rtl/sar_if.sv
// Search controller bus: start/window request, comparer probe/flags, status.
// master = search controller, slave = requester plus comparer side.
interface sar_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             start;
  logic [WIDTH-1:0] win_lo;
  logic [WIDTH-1:0] win_hi;
  logic [2:0]       f_in;
  logic [WIDTH-1:0] probe;
  logic             busy;
  logic             done;
  logic             found;
  logic [WIDTH-1:0] result;
  logic [CNT_W-1:0] steps;
  logic             error;

  modport master (
    input  start, win_lo, win_hi, f_in,
    output probe, busy, done, found,
    output result, steps, error
  );

  modport slave (
    output start, win_lo, win_hi, f_in,
    input  probe, busy, done, found,
    input  result, steps, error
  );
endinterface

// File: rtl/sar_search_ctrl.sv
// Binary-search initiator driving a combinational comparer (probe on b).
// Ports: clk, rst_n (sync, active low), bus (sar_if.master): start,
// win_lo/win_hi in; f_in {gt,lt,eq} in; probe/busy/done/found/result/
// steps/error out. Macro SAR_FLAG_CHECK_EN: non-one-hot flags -> error.
module sar_search_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input logic   clk,
  input logic   rst_n,
  sar_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    CMP,
    DONE
  } state_t;

  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [WIDTH-1:0] ZERO = '0;

  state_t           st_q, st_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] pr_q, pr_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             fnd_q, fnd_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stp_q, stp_d;

  // Midpoint sum one bit wider so lo+hi never wraps.
  logic [WIDTH:0]   sum;
  assign sum = {1'b0, lo_q} + {1'b0, hi_q};

  // Flag decode reduced to exactly one active class.
  logic is_eq, is_gt, is_lt, is_err;

`ifdef SAR_FLAG_CHECK_EN
  assign is_eq  = (bus.f_in == 3'b001);
  assign is_gt  = (bus.f_in == 3'b100);
  assign is_lt  = (bus.f_in == 3'b010);
  assign is_err = ~(is_eq | is_gt | is_lt);
`else
  // eq wins, then gt; anything else (incl. 000) is lt.
  assign is_eq  = bus.f_in[0];
  assign is_gt  = ~bus.f_in[0] & bus.f_in[2];
  assign is_lt  = ~bus.f_in[0] & ~bus.f_in[2];
  assign is_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q  <= IDLE;
      lo_q  <= '0;
      hi_q  <= '0;
      pr_q  <= '0;
      res_q <= '0;
      fnd_q <= 1'b0;
      err_q <= 1'b0;
      stp_q <= '0;
    end else begin
      st_q  <= st_d;
      lo_q  <= lo_d;
      hi_q  <= hi_d;
      pr_q  <= pr_d;
      res_q <= res_d;
      fnd_q <= fnd_d;
      err_q <= err_d;
      stp_q <= stp_d;
    end
  end

  always_comb begin
    st_d  = st_q;
    lo_d  = lo_q;
    hi_d  = hi_q;
    pr_d  = pr_q;
    res_d = res_q;
    fnd_d = fnd_q;
    err_d = err_q;
    stp_d = stp_q;
    unique case (st_q)
      IDLE: begin
        if (bus.start) begin
          lo_d  = bus.win_lo;
          hi_d  = bus.win_hi;
          res_d = '0;
          fnd_d = 1'b0;
          err_d = 1'b0;
          stp_d = '0;
          if (bus.win_lo > bus.win_hi)
            st_d = DONE;
          else
            st_d = CALC;
        end
      end
      CALC: begin
        pr_d = sum[WIDTH:1];
        st_d = CMP;
      end
      CMP: begin
        stp_d = stp_q + 1'b1;
        unique case (1'b1)
          is_eq: begin
            fnd_d = 1'b1;
            res_d = pr_q;
            st_d  = DONE;
          end
          is_gt: begin
            if (pr_q == MAX) begin
              st_d = DONE;
            end else begin
              lo_d = pr_q + 1'b1;
              st_d = (lo_d > hi_q) ? DONE : CALC;
            end
          end
          is_lt: begin
            if (pr_q == ZERO) begin
              st_d = DONE;
            end else begin
              hi_d = pr_q - 1'b1;
              st_d = (lo_q > hi_d) ? DONE : CALC;
            end
          end
          is_err: begin
            err_d = 1'b1;
            fnd_d = 1'b0;
            res_d = '0;
            st_d  = DONE;
          end
          default: st_d = DONE;
        endcase
      end
      DONE: st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  assign bus.probe  = pr_q;
  assign bus.busy   = (st_q == CALC) || (st_q == CMP);
  assign bus.done   = (st_q == DONE);
  assign bus.found  = fnd_q;
  assign bus.result = res_q;
  assign bus.steps  = stp_q;
  assign bus.error  = err_q;

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Randomized bench for sar_search_ctrl against a plain arithmetic
// binary-search model; comparer modelled as an ideal magnitude compare.
module tb_sar_search_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sar_if #(.WIDTH(8), .CNT_W(4)) bus ();

  sar_search_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   tgt;
  logic force_en = 1'b0;

  assign bus.f_in = force_en ? 3'b011 :
    {tgt > int'(bus.probe),
     tgt < int'(bus.probe),
     tgt == int'(bus.probe)};

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(string tag,
                       logic [63:0] got,
                       logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // Reference: classic binary search with integers.
  int m_found, m_res, m_steps, m_probe;
  task automatic model(int wl, int wh, int t);
    int lo, hi, p;
    lo = wl;
    hi = wh;
    m_found = 0;
    m_res = 0;
    m_steps = 0;
    while (lo <= hi) begin
      p = (lo + hi) / 2;
      m_probe = p;
      m_steps++;
      if (t == p) begin
        m_found = 1;
        m_res = p;
        break;
      end else if (t > p) begin
        lo = p + 1;
      end else begin
        hi = p - 1;
      end
    end
  endtask

  // Issues start, waits for done; returns cycles start->done.
  int cyc;
  task automatic launch(int wl, int wh, int t);
    tgt = t;
    bus.win_lo = 8'(wl);
    bus.win_hi = 8'(wh);
    bus.start = 1'b1;
    cyc = 0;
    while (cyc < 40) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      cyc++;
      if (bus.done) break;
    end
  endtask

  task automatic run(string tag, int wl, int wh, int t);
    int exp_cyc;
    launch(wl, wh, t);
    model(wl, wh, t);
    exp_cyc = (m_steps == 0) ? 1 : 2 * m_steps + 1;
    check({tag, ".done"}, 64'(bus.done), 64'd1);
    check({tag, ".cyc"}, 64'(cyc), 64'(exp_cyc));
    check({tag, ".busy"}, 64'(bus.busy), 64'd0);
    check({tag, ".found"}, 64'(bus.found),
          64'(m_found));
    check({tag, ".result"}, 64'(bus.result),
          64'(m_res));
    check({tag, ".steps"}, 64'(bus.steps),
          64'(m_steps));
    check({tag, ".error"}, 64'(bus.error), 64'd0);
    if (m_steps != 0)
      check({tag, ".probe"}, 64'(bus.probe),
            64'(m_probe));
    @(posedge clk);
    #1;
    check({tag, ".done_pulse"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    int wl, wh, t, seen;
    bus.start = 1'b0;
    bus.win_lo = '0;
    bus.win_hi = '0;
    tgt = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.outs",
          64'({bus.probe, bus.busy, bus.done,
               bus.found, bus.result, bus.steps,
               bus.error}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run("mid", 0, 255, 8'h7F);
    run("top", 0, 255, 8'hFF);
    run("below", 8'h10, 8'h20, 8'h05);
    check("below.probe", 64'(bus.probe), 64'h10);
    run("empty", 8'h40, 8'h3F, 8'h40);
    check("empty.steps", 64'(bus.steps), 64'd0);
    run("above", 8'hF0, 8'hFF, 300);

    // Restart while busy must be ignored.
    tgt = 200;
    bus.win_lo = 0;
    bus.win_hi = 255;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    check("busy.start", 64'(bus.busy), 64'd1);
    bus.win_lo = 8'h50;
    bus.win_hi = 8'h40;
    @(posedge clk);
    #1;
    check("busy.ignore", 64'(bus.done), 64'd0);
    bus.start = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (bus.done) break;
    end
    check("busy.found", 64'(bus.found), 64'd1);
    check("busy.result", 64'(bus.result), 64'd200);

    // Reset during CMP: state cleared, no done.
    tgt = 0;
    bus.win_lo = 0;
    bus.win_hi = 255;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst.outs",
          64'({bus.probe, bus.busy, bus.done,
               bus.found, bus.result, bus.steps,
               bus.error}), 64'd0);
    rst_n = 1'b1;
    seen = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      seen += int'(bus.done);
    end
    check("rst.nodone", 64'(seen), 64'd0);
    run("zero", 0, 255, 0);
    check("zero.steps", 64'(bus.steps), 64'd8);

    for (int i = 0; i < 40; i++) begin
      wl = int'($urandom_range(255, 0));
      wh = int'($urandom_range(255, 0));
      if (i % 8 == 0) begin
        wl = 0;
        wh = 255;
      end
      if (wl <= wh && $urandom_range(9, 0) < 7)
        t = int'($urandom_range(wh, wl));
      else
        t = int'($urandom_range(255, 0));
      run("rnd", wl, wh, t);
    end

    // Malformed flags 011 on the first compare.
    force_en = 1'b1;
    launch(0, 255, 8'h33);
    force_en = 1'b0;
    check("flag.done", 64'(bus.done), 64'd1);
    check("flag.steps", 64'(bus.steps), 64'd1);
`ifdef SAR_FLAG_CHECK_EN
    check("flag.error", 64'(bus.error), 64'd1);
    check("flag.found", 64'(bus.found), 64'd0);
    check("flag.result", 64'(bus.result), 64'd0);
`else
    check("flag.error", 64'(bus.error), 64'd0);
    check("flag.found", 64'(bus.found), 64'd1);
    check("flag.result", 64'(bus.result), 64'h7F);
`endif
    @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
